xadc_multi_packetizer: RTL and testbench

XADC_MULTI_PACKETIZER -- requirements
Module: xadc_multi_packetizer

---
 rtl/xadc_packet_package.sv | 13 +
 rtl/xadc_multi_packetizer.sv | 151 +++++++++++++++
 tb/tb_xadc_multi_packetizer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_packet_package.sv
// Shared types and constants for the XADC multi-channel sample packetizer.
package xadc_packet_package;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    SEND_HEADER   = 2'd1,
    SEND_DATA     = 2'd2,
    SEND_CHECKSUM = 2'd3
  } pkt_state_e;

  localparam logic [3:0] HEADER_TYPE_DEFAULT = 4'h1;

endpackage

// File: rtl/xadc_multi_packetizer.sv
// Captures one sample from every enabled channel in a single cycle and streams
// it out as a byte packet: header, per-channel sample bytes (MSB first), XOR checksum.
//
// state         | meaning
// IDLE          | tracking channel_mask, waiting for all enabled channels valid
// SEND_HEADER   | presenting {HEADER_TYPE, seq}
// SEND_DATA     | presenting sample bytes of enabled channels, ascending index
// SEND_CHECKSUM | presenting XOR of header and data bytes (CHECKSUM_EN only)
module xadc_multi_packetizer
  import xadc_packet_package::*;
#(
  parameter int         NUM_CHANNELS = 2,
  parameter int         SAMPLE_WIDTH = 16,
  parameter int         CHECKSUM_EN  = 1,
  parameter logic [3:0] HEADER_TYPE  = HEADER_TYPE_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS-1:0]              channel_mask,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata,
  input  logic [NUM_CHANNELS-1:0]              s_tvalid,
  output logic [NUM_CHANNELS-1:0]              s_tready,
  output logic [7:0]                           m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic                                 busy
);

  localparam int BPS    = SAMPLE_WIDTH / 8;
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FLAT_W = NUM_CHANNELS * SAMPLE_WIDTH;

  pkt_state_e              state, state_nxt;
  logic [NUM_CHANNELS-1:0] mask_latched;
  logic [FLAT_W-1:0]       sample_q;
  logic [FLAT_W-1:0]       sample_shift;
  logic [CH_W-1:0]         ch_idx;
  logic [CH_W-1:0]         first_ch;
  logic [CH_W-1:0]         next_ch;
  logic                    has_next;
  logic [1:0]              byte_cnt;
  logic [3:0]              seq;
  logic [7:0]              chk_q;
  logic [7:0]              header;
  logic [7:0]              cur_byte;
  logic                    capture;
  logic                    last_data;
  logic                    hs;

  // rst gates capture so s_tready is held low while reset is asserted
  assign capture = rst && (state == IDLE) && (channel_mask != '0) &&
                   ((s_tvalid & channel_mask) == channel_mask);
  assign s_tready  = capture ? channel_mask : '0;
  assign header    = {HEADER_TYPE, seq};
  assign busy      = (state != IDLE);
  assign hs        = m_tvalid && m_tready;
  assign last_data = (byte_cnt == 2'd0) && !has_next;

  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_mask[i]) first_ch = CH_W'(i);
      if (mask_latched[i] && (i > int'(ch_idx))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    sample_shift = sample_q >> (int'(ch_idx) * SAMPLE_WIDTH + int'(byte_cnt) * 8);
    cur_byte     = sample_shift[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdata   = '0;
    case (state)
      IDLE: begin
        if (capture) state_nxt = SEND_HEADER;
      end
      SEND_HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = header;
        if (m_tready) state_nxt = SEND_DATA;
      end
      SEND_DATA: begin
        m_tvalid = 1'b1;
        m_tdata  = cur_byte;
        m_tlast  = (CHECKSUM_EN == 0) && last_data;
        if (m_tready && last_data)
          state_nxt = (CHECKSUM_EN != 0) ? SEND_CHECKSUM : IDLE;
      end
      SEND_CHECKSUM: begin
        m_tvalid = 1'b1;
        m_tdata  = chk_q;
        m_tlast  = 1'b1;
        if (m_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_latched <= '0;
      sample_q     <= '0;
      ch_idx       <= '0;
      byte_cnt     <= '0;
      seq          <= '0;
      chk_q        <= '0;
    end else begin
      if (state == IDLE) mask_latched <= channel_mask;
      if (capture) begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          if (channel_mask[i])
            sample_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        ch_idx   <= first_ch;
        byte_cnt <= 2'(BPS - 1);
      end
      if (hs) begin
        case (state)
          SEND_HEADER: chk_q <= header;
          SEND_DATA: begin
            chk_q <= chk_q ^ cur_byte;
            // byte_cnt counts down so the MSB of each sample goes first
            if (byte_cnt == 2'd0) begin
              ch_idx   <= next_ch;
              byte_cnt <= 2'(BPS - 1);
            end else begin
              byte_cnt <= byte_cnt - 2'd1;
            end
          end
          default: ;
        endcase
        if (m_tlast) seq <= seq + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_xadc_multi_packetizer.sv
// Scoreboard bench for xadc_multi_packetizer: default config plus a 4ch/24-bit/no-checksum instance.
module tb_xadc_multi_packetizer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  channel_mask;
  logic [31:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;

  xadc_multi_packetizer dut (
    .clk(clk), .rst(rst), .channel_mask(channel_mask), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy)
  );

  logic [3:0]  b_mask;
  logic [95:0] b_tdata;
  logic [3:0]  b_tvalid;
  logic [3:0]  b_tready;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid;
  logic        b_m_tready;
  logic        b_m_tlast;
  logic        b_busy;

  xadc_multi_packetizer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(24), .CHECKSUM_EN(0)) dut_b (
    .clk(clk), .rst(rst), .channel_mask(b_mask), .s_tdata(b_tdata),
    .s_tvalid(b_tvalid), .s_tready(b_tready), .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid),
    .m_tready(b_m_tready), .m_tlast(b_m_tlast), .busy(b_busy)
  );

  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  typedef struct { logic [1:0] mask; logic [15:0] d0; logic [15:0] d1; logic [1:0] vld; int mode; } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         bytes_seen = 0;
  int         rdy_mode = 0;
  logic [3:0] exp_seq = 4'd0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // m_tready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
  end

  // Output monitor: pops the scoreboard on each handshake, checks stall stability
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_tvalid), 32'd1);
        chk("stall_data", 32'(m_tdata), 32'(prev_data));
        chk("stall_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h, required no byte", m_tdata);
        end else begin
          mon_e = sb.pop_front();
          chk("byte_data", 32'(m_tdata), 32'(mon_e.data));
          chk("byte_last", 32'(m_tlast), 32'(mon_e.last));
        end
        bytes_seen++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic push_pkt(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1);
    logic [7:0]  c;
    logic [7:0]  hdr;
    logic [15:0] d;
    hdr = {4'h1, exp_seq};
    c   = hdr;
    sb.push_back('{hdr, 1'b0});
    for (int ch = 0; ch < 2; ch++) begin
      if (mask[ch]) begin
        d = (ch == 0) ? d0 : d1;
        sb.push_back('{d[15:8], 1'b0});
        sb.push_back('{d[7:0], 1'b0});
        c = c ^ d[15:8] ^ d[7:0];
      end
    end
    sb.push_back('{c, 1'b1});
    exp_seq = exp_seq + 4'd1;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk); #1;
    while (busy && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", t);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 400) begin
      @(negedge clk); #3;
      t++;
    end
    if (sb.size() != 0 || busy) begin
      n_vec++;
      n_err++;
      $display("FAIL pkt_timeout: %0d bytes outstanding busy=%0b, required 0 and 0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic send_pkt(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [1:0] vld, input int mode);
    rdy_mode = mode;
    wait_idle();
    channel_mask = mask;
    s_tdata      = {d1, d0};
    s_tvalid     = vld;
    push_pkt(mask, d0, d1);
    #1;
    chk("s_tready_capture", 32'(s_tready), 32'(mask));
    @(negedge clk); #1;
    chk("s_tready_after", 32'(s_tready), 32'd0);
    chk("busy_after_capture", 32'(busy), 32'd1);
    // change the mask mid-packet; the packet in flight must not notice
    channel_mask = 2'($urandom);
    s_tvalid     = 2'b00;
    wait_done();
  endtask

  vec_t       vecs[6];
  logic [7:0] b_exp[7];
  int         k;
  int         t;
  int         base;

  initial begin
    vecs[0] = '{2'b11, 16'h0ABC, 16'h0123, 2'b11, 0};
    vecs[1] = '{2'b10, 16'h7777, 16'h0FFF, 2'b10, 0};
    vecs[2] = '{2'b11, 16'h0ABC, 16'h0123, 2'b11, 1};
    vecs[3] = '{2'b01, 16'h55AA, 16'h0000, 2'b11, 2};
    vecs[4] = '{2'b11, 16'hFFFF, 16'h8001, 2'b11, 2};
    vecs[5] = '{2'b10, 16'h1234, 16'hABCD, 2'b11, 1};
    b_exp   = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b0;
    channel_mask = 2'b11; s_tdata = '0; s_tvalid = 2'b11;
    b_mask = 4'b0101; b_tdata = '0; b_tvalid = 4'b1111; b_m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_b_s_tready", 32'(b_tready), 32'd0);
    s_tvalid = 2'b00; b_tvalid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;

    // 4 channel, 24-bit, no checksum: mask 0101 gives a 7-byte packet
    @(negedge clk);
    b_tdata  = {24'hDEAD01, 24'h445566, 24'hBEEF02, 24'h112233};
    b_tvalid = 4'b1111;
    #1;
    chk("b_s_tready", 32'(b_tready), 32'h5);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      b_tvalid = 4'b0000;
      #2;
      if (b_m_tvalid && b_m_tready) begin
        if (k < 7) begin
          chk("b_byte", 32'(b_m_tdata), 32'(b_exp[k]));
          chk("b_last", 32'(b_m_tlast), 32'(k == 6));
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL b_extra_byte: got %02h, required none", b_m_tdata);
        end
        k++;
      end
    end
    chk("b_pkt_len", 32'(k), 32'd7);

    for (int i = 0; i < 6; i++)
      send_pkt(vecs[i].mask, vecs[i].d0, vecs[i].d1, vecs[i].vld, vecs[i].mode);

    // partial valid and empty mask must never capture
    rdy_mode = 0;
    wait_idle();
    channel_mask = 2'b11; s_tvalid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("partial_s_tready", 32'(s_tready), 32'd0);
      @(negedge clk); #1;
      chk("partial_busy", 32'(busy), 32'd0);
    end
    channel_mask = 2'b00; s_tvalid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mask0_s_tready", 32'(s_tready), 32'd0);
      @(negedge clk); #1;
      chk("mask0_busy", 32'(busy), 32'd0);
    end
    s_tvalid = 2'b00;

    // reset two bytes into a packet
    wait_idle();
    channel_mask = 2'b11; s_tdata = {16'h5A5A, 16'hC3C3}; s_tvalid = 2'b11;
    push_pkt(2'b11, 16'hC3C3, 16'h5A5A);
    @(negedge clk); #1;
    s_tvalid = 2'b00;
    base = bytes_seen;
    t = 0;
    while (bytes_seen < base + 2 && t < 50) begin
      @(negedge clk); #3;
      t++;
    end
    if (bytes_seen < base + 2) begin
      n_vec++;
      n_err++;
      $display("FAIL rst_mid_wait: %0d bytes seen, required 2", bytes_seen - base);
    end
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = 2'b11;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_tdata", 32'(m_tdata), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    sb.delete();
    exp_seq = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    s_tvalid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("post_rst_idle", 32'(m_tvalid), 32'd0);
    end

    // 17 packets from seq 0: header nibbles 0..15 then wrap to 0
    for (int i = 0; i < 17; i++)
      send_pkt(2'(1 + $urandom_range(0, 2)), 16'($urandom), 16'($urandom), 2'b11, i % 3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
